// File: rtl/dual_port_ram_pkg.sv
// Shared constants and helpers for dual_port_ram_pipelined and its response FIFO.
package dual_port_ram_pkg;

    // Deepest read pipeline the design supports.
    localparam int READ_LATENCY_MAX = 4;

    // Wide enough to count 0..READ_LATENCY_MAX+1 outstanding reads.
    localparam int CREDIT_W = $clog2(READ_LATENCY_MAX + 2);

    // One slot per pipeline stage plus one, so every credited read has a home.
    function automatic int resp_fifo_depth(input int read_latency);
        return read_latency + 1;
    endfunction

endpackage

// File: rtl/dual_port_ram_pipelined_fifo.sv
// ram_resp_fifo: show-ahead FIFO holding read responses that the consumer
// has not yet taken. The head word is visible whenever empty is low.
module ram_resp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = store[rd_ptr];

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    // Pointers wrap explicitly since DEPTH is usually not a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dual_port_ram_pipelined.sv
// dual_port_ram_pipelined: byte-strobed write port plus a handshaked read
// port with READ_LATENCY-deep pipeline and a credit-limited response FIFO.
// Optional macro DUAL_PORT_RAM_FWD_EN: same-cycle read/write collisions
// return the merged (write-forwarded) word instead of the old word.
module dual_port_ram_pipelined
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_DEPTH    = 256,
    parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic                    read_req_valid,
    output logic                    read_req_ready,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_data_valid,
    input  logic                    read_data_ready,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb
);
    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int FIFO_DEPTH = resp_fifo_depth(READ_LATENCY);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [CREDIT_W-1:0]   outstanding;
    logic                  accept;
    logic                  resp_hs;
    logic                  pipe_out_vld;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign read_req_ready = (outstanding < CREDIT_MAX);
    assign accept         = read_req_valid && read_req_ready;
    assign resp_hs        = read_data_valid && read_data_ready;
    assign old_word       = mem[read_addr];
    assign pipe_out_vld   = vld_pipe[READ_LATENCY-1];

    // Byte-granular array write; never stalled and never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (write_strb[i]) mem[write_addr][i*8 +: 8] <= write_data[i*8 +: 8];
        end
    end

    // Word captured by the array read register (read-first unless forwarding).
    always_comb begin
        rd_word = old_word;
`ifdef DUAL_PORT_RAM_FWD_EN
        if (read_addr == write_addr) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (write_strb[i]) rd_word[i*8 +: 8] = write_data[i*8 +: 8];
            end
        end
`endif
    end

    // Valid-tagged read pipeline; stage 0 is the array read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_data[i] <= '0;
        end else begin
            vld_pipe[0] <= accept;
            if (accept) pipe_data[0] <= rd_word;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    // Credit counter: one credit per accepted read, returned on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, resp_hs})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // A completion that meets an empty FIFO and a ready consumer bypasses the
    // FIFO, so the response appears exactly READ_LATENCY cycles after accept.
    assign fifo_push = pipe_out_vld && !(fifo_empty && read_data_ready);
    assign fifo_pop  = !fifo_empty && read_data_ready;

    assign read_data_valid = !fifo_empty || pipe_out_vld;
    assign read_data       = fifo_empty ? pipe_data[READ_LATENCY-1] : fifo_head;

    ram_resp_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pipe_data[READ_LATENCY-1]),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_dual_port_ram_pipelined.sv
// Scoreboard bench for dual_port_ram_pipelined: a driver updates a plain
// array model and queues expected responses; a monitor pops and compares.
module tb_dual_port_ram_pipelined;
    localparam int L = 2;

    logic        clk = 0;
    logic        rst = 1;
    logic [7:0]  read_addr = '0;
    logic        read_req_valid = 0;
    logic        read_req_ready;
    logic [63:0] read_data;
    logic        read_data_valid;
    logic        read_data_ready = 0;
    logic [7:0]  write_addr = '0;
    logic [63:0] write_data = '0;
    logic [7:0]  write_strb = '0;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;
    int accepted_count = 0;
    logic last_acc = 0;
    logic [63:0] mm [256];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    dual_port_ram_pipelined #(
        .DATA_WIDTH   (64),
        .MEM_DEPTH    (256),
        .READ_LATENCY (L)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .read_addr       (read_addr),
        .read_req_valid  (read_req_valid),
        .read_req_ready  (read_req_ready),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .read_data_ready (read_data_ready),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .write_strb      (write_strb)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle at a negedge; the model sees what the DUT will see at
    // the following posedge (read first, then write).
    task automatic step(input logic rv, input logic [7:0] ra, input logic rr,
                        input logic [7:0] wa, input logic [63:0] wd, input logic [7:0] ws);
        logic [63:0] e;
        read_req_valid  = rv;
        read_addr       = ra;
        read_data_ready = rr;
        write_addr      = wa;
        write_data      = wd;
        write_strb      = ws;
        last_acc = rv && read_req_ready && !rst;
        if (last_acc) begin
            e = mm[ra];
`ifdef DUAL_PORT_RAM_FWD_EN
            if (wa == ra)
                for (int i = 0; i < 8; i++)
                    if (ws[i]) e[i*8 +: 8] = wd[i*8 +: 8];
`endif
            exp_q.push_back(e);
            accepted_count++;
        end
        if (!rst)
            for (int i = 0; i < 8; i++)
                if (ws[i]) mm[wa][i*8 +: 8] = wd[i*8 +: 8];
        @(negedge clk);
    endtask

    task automatic idle(input logic rr, input int n);
        for (int i = 0; i < n; i++) step(0, 8'd0, rr, 8'd0, 64'd0, 8'd0);
    endtask

    // Monitor: checks every handshake against the queue and output stability
    // while stalled.
    logic        prev_stall = 0;
    logic [63:0] prev_data = '0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {63'd0, read_data_valid}, 64'd1);
                chk("hold_data", read_data, prev_data);
            end
            if (read_data_valid && read_data_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got %h expected no response", read_data);
                end else begin
                    chk("resp_data", read_data, exp_q.pop_front());
                end
            end
            prev_stall = read_data_valid && !read_data_ready;
            prev_data  = read_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, acc0, h0, guard;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, read_data_valid}, 64'd0);
        chk("rst_data", read_data, 64'd0);
        chk("rst_ready", {63'd0, read_req_ready}, 64'd1);
        rst = 0;

        // Known contents everywhere
        for (int a = 0; a < 256; a++)
            step(0, 8'd0, 1, 8'(a), {$urandom, $urandom}, 8'hFF);

        // Basic write then read, with latency
        step(0, 8'd0, 1, 8'd5, 64'h1122334455667788, 8'hFF);
        step(1, 8'd5, 1, 8'd0, 64'd0, 8'd0);
        for (int k = 1; k < L; k++) begin
            chk("latency_early", {63'd0, read_data_valid}, 64'd0);
            idle(1, 1);
        end
        chk("latency_valid", {63'd0, read_data_valid}, 64'd1);
        idle(1, 3);

        // Byte strobe
        step(0, 8'd0, 1, 8'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        step(1, 8'd5, 1, 8'd0, 64'd0, 8'd0);
        idle(1, 4);

        // Collision at addr 7
        step(0, 8'd0, 1, 8'd7, 64'd0, 8'hFF);
        step(1, 8'd7, 1, 8'd7, 64'hFFFFFFFFFFFFFFFF, 8'h01);
        idle(1, 5);

        // Streaming: 16 back-to-back reads, no bubbles
        h0 = hs_count;
        acc0 = accepted_count;
        for (int i = 0; i < 16; i++) step(1, 8'(i + 16), 1, 8'd0, 64'd0, 8'd0);
        idle(1, 2);
        chk("stream_accepted", 64'(accepted_count - acc0), 64'd16);
        chk("stream_count", 64'(hs_count - h0), 64'd16);
        idle(1, 3);

        // Backpressure
        idx = 0;
        acc0 = accepted_count;
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(idx), 0, 8'd0, 64'd0, 8'd0);
            if (last_acc) idx++;
        end
        chk("bp_accepted", 64'(accepted_count - acc0), 64'(L + 1));
        chk("bp_ready_low", {63'd0, read_req_ready}, 64'd0);
        chk("bp_valid", {63'd0, read_data_valid}, 64'd1);
        step(1, 8'(idx), 1, 8'd0, 64'd0, 8'd0);
        if (last_acc) idx++;
        chk("bp_ready_back", {63'd0, read_req_ready}, 64'd1);
        guard = 0;
        while (idx < 10 && guard < 60) begin
            step(1, 8'(idx), 1, 8'd0, 64'd0, 8'd0);
            if (last_acc) idx++;
            guard++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd10);
        idle(1, 6);

        // Randomised traffic with collisions and backpressure
        for (int i = 0; i < 400; i++) begin
            logic [7:0] ws;
            ws = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 7), 8'($urandom_range(0, 15)),
                 {$urandom, $urandom}, ws);
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            idle(1, 1);
            guard++;
        end
        idle(1, 1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // Reset with responses buffered
        guard = 0;
        acc0 = accepted_count;
        while (accepted_count - acc0 < 3 && guard < 10) begin
            step(1, 8'd5, 0, 8'd0, 64'd0, 8'd0);
            guard++;
        end
        idle(0, 2);
        chk("pre_rst_valid", {63'd0, read_data_valid}, 64'd1);
        rst = 1;
        exp_q.delete();
        idle(1, 1);
        chk("midrst_valid", {63'd0, read_data_valid}, 64'd0);
        chk("midrst_data", read_data, 64'd0);
        chk("midrst_ready", {63'd0, read_req_ready}, 64'd1);
        rst = 0;
        idle(1, 6);
        chk("post_rst_ready", {63'd0, read_req_ready}, 64'd1);
        h0 = hs_count;
        step(1, 8'd5, 1, 8'd0, 64'd0, 8'd0);
        idle(1, 4);
        chk("post_rst_read", 64'(hs_count - h0), 64'd1);
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
